fm_freq_demod: RTL and testbench

Recovers the 12-bit offset-binary modulating sample from a 64-bit instantaneous frequency control word. It is the exact inverse of the FM frequency-word modulator: given a carrier word and a modulated word, it reproduces the original 12-bit sample. It sits in the self-test/loopback path between the FM modulator's `FM_Freq` output and the sample checker, so DAC modulation data can be verified without analog capture.

---
 rtl/fm_freq_demod_if.sv | 31 +++
 rtl/fm_freq_demod.sv | 146 ++++++++++++++
 tb/tb_fm_freq_demod.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fm_freq_demod_if.sv
// Handshake and result bundle of the FM frequency-word demodulator.
// The master side supplies frequency words; the slave side is the demodulator.
interface fm_freq_demod_if;
    logic        freq_in_valid;
    logic [63:0] freq_in;
    logic [63:0] freq_ctrl_car;
    logic        freq_in_ready;
    logic [11:0] dac_demod_w12;
    logic        demod_valid;
    logic        overrange;

    modport master (
        output freq_in_valid,
        output freq_in,
        output freq_ctrl_car,
        input  freq_in_ready,
        input  dac_demod_w12,
        input  demod_valid,
        input  overrange
    );

    modport slave (
        input  freq_in_valid,
        input  freq_in,
        input  freq_ctrl_car,
        output freq_in_ready,
        output dac_demod_w12,
        output demod_valid,
        output overrange
    );
endinterface

// File: rtl/fm_freq_demod.sv
// FM frequency-word demodulator: recovers the 12-bit offset-binary sample from
// a modulated frequency word and its carrier word. Exact inverse of the
// modulator's floor(Kf * (s - MID) / 4096) mapping, using a 13-step restoring
// divider with fixed 16-cycle throughput.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a word; captures freq_in / freq_ctrl_car on accept
// PREP  | sign/magnitude of the deviation, range check, divider load
// DIV   | one quotient bit per cycle, MSB first (13 cycles)
// OUT   | ceiling correction, clamp, publish sample and pulse valid
module fm_freq_demod #(
    parameter logic [63:0] KF  = 64'd76861433640456500,
    parameter logic [11:0] MID = 12'd2047
) (
    input  logic               clk,
    input  logic               rst,
    fm_freq_demod_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, PREP, DIV, OUT} state_t;

    state_t      state, state_nxt;

    logic [63:0] fin_r, car_r;
    logic        neg_r, big_r;
    logic [76:0] rem_r, dvs_r;
    logic [12:0] q_r;
    logic [3:0]  cnt_r;

    logic [11:0] dac_r;
    logic        valid_r, ovr_r;
    logic        ready_c;

    logic        neg_c, big_c, ge_c, ovr_c;
    logic [63:0] mag_c;
    logic [13:0] qc_c;
    logic [11:0] sample_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; the division length is fixed, so latency never depends on data.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.freq_in_valid) state_nxt = PREP;
            PREP: state_nxt = DIV;
            DIV:  if (cnt_r == 4'd0) state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: only IDLE accepts a word.
    always_comb begin
        ready_c = (state == IDLE);
    end

    // Deviation sign/magnitude: whichever operand is larger is the minuend, so nothing wraps.
    always_comb begin
        neg_c = (fin_r < car_r);
        mag_c = neg_c ? (car_r - fin_r) : (fin_r - car_r);
        big_c = ({3'b000, mag_c} >= {2'b00, KF, 1'b0});
        ge_c  = (rem_r >= dvs_r);
    end

    // Ceiling of the quotient undoes the modulator's floor; then clamp to the 12-bit code range.
    always_comb begin
        qc_c     = {1'b0, q_r} + {13'd0, (rem_r != 77'd0)};
        if (big_r) qc_c = 14'd8191;
        sample_c = MID;
        ovr_c    = 1'b0;
        if (!neg_r) begin
            if (qc_c > 14'd2048) begin
                sample_c = 12'd4095;
                ovr_c    = 1'b1;
            end else begin
                sample_c = MID + qc_c[11:0];
            end
        end else begin
            if (qc_c > 14'd2047) begin
                sample_c = 12'd0;
                ovr_c    = 1'b1;
            end else begin
                sample_c = MID - qc_c[11:0];
            end
        end
    end

    // Datapath: capture, divider load, restoring division steps, result publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_r   <= '0;
            car_r   <= '0;
            neg_r   <= 1'b0;
            big_r   <= 1'b0;
            rem_r   <= '0;
            dvs_r   <= '0;
            q_r     <= '0;
            cnt_r   <= '0;
            dac_r   <= MID;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.freq_in_valid) begin
                        fin_r <= bus.freq_in;
                        car_r <= bus.freq_ctrl_car;
                    end
                end
                PREP: begin
                    neg_r <= neg_c;
                    big_r <= big_c;
                    rem_r <= {1'b0, mag_c, 12'd0};
                    dvs_r <= {1'b0, KF, 12'd0};
                    q_r   <= '0;
                    cnt_r <= 4'd12;
                end
                DIV: begin
                    if (ge_c) rem_r <= rem_r - dvs_r;
                    q_r   <= {q_r[11:0], ge_c};
                    dvs_r <= dvs_r >> 1;
                    if (cnt_r != 4'd0) cnt_r <= cnt_r - 4'd1;
                end
                OUT: begin
                    dac_r   <= sample_c;
                    ovr_r   <= ovr_c;
                    valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.freq_in_ready = ready_c;
    assign bus.dac_demod_w12 = dac_r;
    assign bus.demod_valid   = valid_r;
    assign bus.overrange     = ovr_r;

endmodule

// File: tb/tb_fm_freq_demod.sv
// Directed self-checking bench for fm_freq_demod. Input words come from a
// model of the FM modulator; expected samples are the codes fed to it.
module tb_fm_freq_demod;

    localparam logic [63:0] KF = 64'd76861433640456500;
    localparam logic [63:0] C  = 64'h4000_0000_0000_0000;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    fm_freq_demod_if bus ();

    fm_freq_demod dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Modulator model: C +/- floor(KF * |s - 2047| / 4096), upward for s above mid.
    function automatic logic [63:0] mod_word(input logic [63:0] car, input int s);
        logic [127:0] p;
        logic [63:0]  d;
        int           k;
        k = (s > 2047) ? (s - 2047) : (2047 - s);
        p = {64'd0, KF} * 128'(k);
        d = p[75:12];
        return (s >= 2047) ? (car + d) : (car - d);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input string tag, input logic [63:0] fin, input logic [63:0] car);
        int n = 0;
        while (!bus.freq_in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, 64'(bus.freq_in_ready), 64'd1);
        bus.freq_in       = fin;
        bus.freq_ctrl_car = car;
        bus.freq_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.freq_in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [11:0] es, input logic eo,
                               input bit chk_lat);
        int n   = 0;
        bit got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (chk_lat && n == 1) check({tag, "_busy"}, 64'(bus.freq_in_ready), 64'd0);
            if (bus.demod_valid) got = 1'b1;
        end
        if (chk_lat) begin
            check({tag, "_latency"}, 64'(n), 64'd15);
            check({tag, "_ready_back"}, 64'(bus.freq_in_ready), 64'd1);
        end else begin
            check({tag, "_got"}, 64'(got), 64'd1);
        end
        check({tag, "_sample"}, 64'(bus.dac_demod_w12), 64'(es));
        check({tag, "_ovr"}, 64'(bus.overrange), 64'(eo));
        if (chk_lat) begin
            @(posedge clk); #1;
            check({tag, "_pulse_end"}, 64'(bus.demod_valid), 64'd0);
            check({tag, "_hold"}, 64'(bus.dac_demod_w12), 64'(es));
        end
    endtask

    int          s_tab [9] = '{0, 1, 1000, 2046, 2047, 2048, 3000, 4094, 4095};
    logic [11:0] expq [$];
    int          accepted, results, cnt;
    logic [63:0] fin_v;

    initial begin
        rst               = 1'b0;
        bus.freq_in_valid = 1'b0;
        bus.freq_in       = '0;
        bus.freq_ctrl_car = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", 64'(bus.dac_demod_w12), 64'd2047);
        check("rst_valid", 64'(bus.demod_valid), 64'd0);
        check("rst_ovr", 64'(bus.overrange), 64'd0);
        check("rst_ready", 64'(bus.freq_in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero deviation
        accept("zero", C, C);
        wait_result("zero", 12'd2047, 1'b0, 1'b1);

        // Directed round trips
        foreach (s_tab[i]) begin
            accept($sformatf("rt%0d", s_tab[i]), mod_word(C, s_tab[i]), C);
            wait_result($sformatf("rt%0d", s_tab[i]), 12'(s_tab[i]), 1'b0, 1'b1);
        end

        // Overrange, small and big paths
        accept("ovr_pos", C + KF, C);
        wait_result("ovr_pos", 12'd4095, 1'b1, 1'b1);
        accept("ovr_big", C - 3 * KF, C);
        wait_result("ovr_big", 12'd0, 1'b1, 1'b1);

        // Reset at E7 of an in-flight word
        accept("rstmid", mod_word(C, 2500), C);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_sample", 64'(bus.dac_demod_w12), 64'd2047);
        check("rstmid_ovr", 64'(bus.overrange), 64'd0);
        check("rstmid_valid", 64'(bus.demod_valid), 64'd0);
        check("rstmid_ready", 64'(bus.freq_in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.demod_valid) cnt++;
        end
        check("rstmid_no_result", 64'(cnt), 64'd0);
        accept("after_rst", mod_word(C, 3000), C);
        wait_result("after_rst", 12'd3000, 1'b0, 1'b1);

        // Carrier and word change right after acceptance
        accept("carchg", mod_word(C, 123), C);
        bus.freq_ctrl_car = C + 64'd12345678901234;
        bus.freq_in       = 64'h1234_5678_9abc_def0;
        wait_result("carchg", 12'd123, 1'b0, 1'b1);

        // Valid pulses while busy are ignored
        accept("busy", mod_word(C, 1000), C);
        cnt = 0;
        for (int c = 1; c < 30; c++) begin
            if (c == 3 || c == 8) begin
                bus.freq_in_valid = 1'b1;
                bus.freq_in       = mod_word(C, 3500);
            end else begin
                bus.freq_in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.demod_valid) begin
                cnt++;
                check("busy_sample", 64'(bus.dac_demod_w12), 64'd1000);
            end
        end
        bus.freq_in_valid = 1'b0;
        check("busy_results", 64'(cnt), 64'd1);

        // Valid held high with data changing every cycle
        accepted = 0;
        results  = 0;
        bus.freq_ctrl_car = C;
        for (int c = 0; c < 80; c++) begin
            int s;
            s = (c * 613 + 5) % 4096;
            bus.freq_in_valid = (c < 64);
            bus.freq_in       = mod_word(C, s);
            if (bus.freq_in_valid && bus.freq_in_ready) begin
                expq.push_back(12'(s));
                accepted++;
            end
            @(posedge clk); #1;
            if (bus.demod_valid) begin
                results++;
                if (expq.size() > 0) check("hs_sample", 64'(bus.dac_demod_w12), 64'(expq.pop_front()));
                else                 check("hs_extra", 64'(bus.dac_demod_w12), 64'h1_0000);
            end
        end
        bus.freq_in_valid = 1'b0;
        check("hs_accepts", 64'(accepted), 64'd4);
        check("hs_results", 64'(results), 64'd4);

        // Full code sweep against the modulator model
        for (int s = 0; s < 4096; s++) begin
            fin_v = mod_word(C, s);
            accept("sweep", fin_v, C);
            wait_result($sformatf("sweep%0d", s), 12'(s), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
